mrelbp_ci_multi_r: RTL and testbench
====================================

Name: mrelbp_ci_multi_r

Overview:
Parametrised centre-intensity (CI) engine for the MRELBP pipeline. It takes the median-filtered pixel stream in raster order and, for NUM_R radii r_k = R_STEP*(k+1), emits one CI bit per valid centre pixel. The bit is (pixel >= frame mean of that radius's valid centres). Means are computed per frame by a shared sequential divider and applied to the following frame.

Parameters:
DATA_W, 8, pixel width
ROWS, 30, frame rows
COLS, 30, frame columns
NUM_R, 4, number of radii (channels); constraint 2*R_STEP*NUM_R < min(ROWS,COLS)
R_STEP, 2, radius increment; r_k = R_STEP*(k+1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pixel_i  in  DATA_W  input pixel, raster order
done_i  in  1  pixel strobe; pixel_i valid when high; gaps allowed
ci_o  out  NUM_R  CI bit per radius
done_o  out  NUM_R  per-radius strobe; ci_o[k] valid when done_o[k]=1
progress_done_o  out  NUM_R  1-cycle pulse after the last centre of radius k in a frame
mean_o  out  NUM_R*DATA_W  current thresholds; radius k at bits [k*DATA_W +: DATA_W]
mean_valid_o  out  1  1-cycle pulse when new thresholds are loaded
overrun_o  out  1  sticky; a frame ended while the divider was busy

Behaviour:
- Reset (async, any time, including mid-frame or mid-divide): row/col counters 0, accumulators 0, FSM to STREAM, thresholds = 2^(DATA_W-1), all outputs 0, overrun_o 0.
- Counters: col increments on each done_i and wraps at COLS-1. row increments on col wrap and wraps at ROWS-1 (end of frame).
- Valid centre for radius k: r_k <= row <= ROWS-1-r_k and r_k <= col <= COLS-1-r_k. Centre count N_k = (ROWS-2r_k)*(COLS-2r_k), a localparam.
- Latency: for a done_i at a valid centre, done_o[k] and ci_o[k] are registered and appear 1 cycle later. ci_o[k] = (pixel_i >= thr_k), unsigned compare. Otherwise done_o[k]=0 and ci_o[k] holds its value.
- progress_done_o[k]: pulses 1 cycle after the done_o[k] of centre (ROWS-1-r_k, COLS-1-r_k).
- Accumulation: sum_k += pixel_i at each valid centre. SUM_W = DATA_W + clog2(ROWS*COLS); no overflow by construction.
- Frame end (done_i at row=ROWS-1, col=COLS-1):
  - All sum_k are copied to snapshot registers and accumulators cleared in the same cycle.
  - The pixel at frame end is still accumulated into the snapshot if it is a valid centre (never valid for r>=1).
- FSM states and transitions:
  - STREAM: idle divider. Goes to DIVIDE on frame end.
  - DIVIDE: restoring divider, quotient = floor(snapshot_k / N_k). Per radius: 1 load cycle + SUM_W iteration cycles. Radii processed k = 0..NUM_R-1 sequentially; quotients kept in staging registers.
  - UPDATE: all thresholds loaded simultaneously from staging; mean_valid_o pulses; back to STREAM. Total DIVIDE+UPDATE = NUM_R*(SUM_W+1)+1 cycles.
- Streaming continues during DIVIDE/UPDATE. Pixels of the new frame use the old thresholds until the UPDATE cycle. A pixel in the UPDATE cycle uses the old thresholds; new thresholds apply from the next cycle.
- Frame end while in DIVIDE/UPDATE: that snapshot is discarded, accumulators are still cleared, and overrun_o is set until reset.
- Quotient width: DATA_W is sufficient, since the mean never exceeds 2^DATA_W-1; the upper quotient bits are dropped.

Optional Feature:
MRELBP_CI_EXT_THR_EN
- Defined: adds ports thr_i (in, DATA_W) and thr_sel_i (in, 1). When thr_sel_i=1, every radius compares against thr_i, sampled in the same cycle as done_i. Mean computation and mean_o continue unchanged.
- Undefined: these ports are absent and the frame mean is always used.

Test Plan:
- Defaults. Reset, then a constant frame of 100 -> all ci_o=0 (100<128). done_o counts 676/484/324/196 for r=2/4/6/8, one progress_done_o per radius. Then mean_valid_o pulses with mean_o=100 for all radii.
- Second constant frame of 100 -> all ci_o=1; mean stays 100.
- Ramp frame pixel=8*col -> mean_o=116 for every radius. Next ramp frame: ci_o=0 for col<=14, ci_o=1 for col>=15, on all radii.
- Random done_i gaps (50% duty) on the ramp frames -> bit-identical ci_o sequence and means; overrun_o stays 0.
- rst asserted after 100 pixels of a frame, then a full constant-100 frame -> outputs 0 during reset, thresholds back to 128, results identical to the first scenario.
- With MRELBP_CI_EXT_THR_EN defined: thr_sel_i=1, thr_i=50, constant frame of 60 -> all ci_o=1, while mean_o still updates to 60.

Source files
------------

// File: rtl/mrelbp_ci_multi_r_if.sv
// Pixel stream and CI result bundle for mrelbp_ci_multi_r.
// thr_i/thr_sel_i exist only when MRELBP_CI_EXT_THR_EN is defined.
interface mrelbp_ci_multi_r_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_R  = 4
);
  logic [DATA_W-1:0]       pixel_i;
  logic                    done_i;
`ifdef MRELBP_CI_EXT_THR_EN
  logic [DATA_W-1:0]       thr_i;
  logic                    thr_sel_i;
`endif
  logic [NUM_R-1:0]        ci_o;
  logic [NUM_R-1:0]        done_o;
  logic [NUM_R-1:0]        progress_done_o;
  logic [NUM_R*DATA_W-1:0] mean_o;
  logic                    mean_valid_o;
  logic                    overrun_o;

`ifdef MRELBP_CI_EXT_THR_EN
  modport master (
    output pixel_i, done_i, thr_i, thr_sel_i,
    input  ci_o, done_o, progress_done_o, mean_o, mean_valid_o, overrun_o
  );
  modport slave (
    input  pixel_i, done_i, thr_i, thr_sel_i,
    output ci_o, done_o, progress_done_o, mean_o, mean_valid_o, overrun_o
  );
`else
  modport master (
    output pixel_i, done_i,
    input  ci_o, done_o, progress_done_o, mean_o, mean_valid_o, overrun_o
  );
  modport slave (
    input  pixel_i, done_i,
    output ci_o, done_o, progress_done_o, mean_o, mean_valid_o, overrun_o
  );
`endif
endinterface

// File: rtl/mrelbp_ci_multi_r.sv
// Multi-radius centre-intensity engine: per-radius CI bits against frame means from a shared
// sequential divider. Define MRELBP_CI_EXT_THR_EN to add the thr_i/thr_sel_i override.
module mrelbp_ci_multi_r #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned COLS   = 30,
  parameter int unsigned NUM_R  = 4,
  parameter int unsigned R_STEP = 2
) (
  input logic                clk,
  input logic                rst,
  mrelbp_ci_multi_r_if.slave bus
);
  localparam int unsigned SUM_W = DATA_W + $clog2(ROWS * COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned IDX_W = (NUM_R > 1) ? $clog2(NUM_R) : 1;
  localparam int unsigned CNT_W = $clog2(SUM_W + 1);
  localparam logic [DATA_W-1:0] THR_RST = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_STREAM, ST_DIVIDE, ST_UPDATE} state_t;

  state_t                       state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [NUM_R-1:0][SUM_W-1:0]  sum_q, sum_d;
  logic [NUM_R-1:0][SUM_W-1:0]  snap_q, snap_d;
  logic [NUM_R-1:0][DATA_W-1:0] thr_q, thr_d;
  logic [NUM_R-1:0][DATA_W-1:0] stage_q, stage_d;
  logic [NUM_R-1:0]             ci_q, ci_d;
  logic [NUM_R-1:0]             done_q, done_d;
  logic [NUM_R-1:0]             last_q, last_d;
  logic [NUM_R-1:0]             prog_q, prog_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SUM_W-1:0]             rem_q, rem_d;
  logic [SUM_W-1:0]             quo_q, quo_d;
  logic                         mean_valid_q, mean_valid_d;
  logic                         overrun_q, overrun_d;

  logic [NUM_R-1:0]             centre, last_centre;
  logic [NUM_R-1:0][SUM_W-1:0]  n_tab;
  logic [NUM_R-1:0][DATA_W-1:0] thr_eff;
  logic                         frame_end;
  logic [SUM_W:0]               rem_sh;
  logic [SUM_W-1:0]             div_sel;

  for (genvar k = 0; k < NUM_R; k++) begin : g_geom
    localparam int unsigned R = R_STEP * (k + 1);
    assign centre[k] = (row_q >= ROW_W'(R)) && (row_q <= ROW_W'(ROWS - 1 - R)) &&
                       (col_q >= COL_W'(R)) && (col_q <= COL_W'(COLS - 1 - R));
    assign last_centre[k] = (row_q == ROW_W'(ROWS - 1 - R)) && (col_q == COL_W'(COLS - 1 - R));
    assign n_tab[k] = SUM_W'((ROWS - 2 * R) * (COLS - 2 * R));
  end

  assign frame_end = bus.done_i && (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));

  always_comb begin
    for (int unsigned k = 0; k < NUM_R; k++) begin
`ifdef MRELBP_CI_EXT_THR_EN
      thr_eff[k] = bus.thr_sel_i ? bus.thr_i : thr_q[k];
`else
      thr_eff[k] = thr_q[k];
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    sum_d        = sum_q;
    snap_d       = snap_q;
    thr_d        = thr_q;
    stage_d      = stage_q;
    ci_d         = ci_q;
    done_d       = '0;
    last_d       = '0;
    prog_d       = last_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    mean_valid_d = 1'b0;
    overrun_d    = overrun_q;
    rem_sh       = '0;
    div_sel      = n_tab[idx_q];

    if (bus.done_i) begin
      if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int unsigned k = 0; k < NUM_R; k++) begin
        if (centre[k]) begin
          done_d[k] = 1'b1;
          ci_d[k]   = (bus.pixel_i >= thr_eff[k]);
          last_d[k] = last_centre[k];
          sum_d[k]  = sum_q[k] + SUM_W'(bus.pixel_i);
        end
      end
      // Snapshot takes the sum including this pixel; a busy divider drops it instead.
      if (frame_end) begin
        for (int unsigned k = 0; k < NUM_R; k++) begin
          if (state_q == ST_STREAM) snap_d[k] = sum_d[k];
          sum_d[k] = '0;
        end
        if (state_q != ST_STREAM) overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_STREAM: begin
        if (frame_end) begin
          state_d = ST_DIVIDE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_DIVIDE: begin
        if (cnt_q == '0) begin
          rem_d = '0;
          quo_d = snap_q[idx_q];
          cnt_d = CNT_W'(1);
        end else begin
          // Restoring step: dividend bits enter the remainder MSB first, quotient bits enter LSB.
          rem_sh = {rem_q, quo_q[SUM_W-1]};
          if (rem_sh >= {1'b0, div_sel}) begin
            rem_d = SUM_W'(rem_sh - {1'b0, div_sel});
            quo_d = {quo_q[SUM_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[SUM_W-1:0];
            quo_d = {quo_q[SUM_W-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(SUM_W)) begin
            stage_d[idx_q] = quo_d[DATA_W-1:0];
            cnt_d          = '0;
            if (idx_q == IDX_W'(NUM_R - 1)) state_d = ST_UPDATE;
            else                            idx_d   = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_UPDATE: begin
        thr_d        = stage_q;
        mean_valid_d = 1'b1;
        state_d      = ST_STREAM;
      end
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_STREAM;
      row_q        <= '0;
      col_q        <= '0;
      sum_q        <= '0;
      snap_q       <= '0;
      thr_q        <= {NUM_R{THR_RST}};
      stage_q      <= '0;
      ci_q         <= '0;
      done_q       <= '0;
      last_q       <= '0;
      prog_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      mean_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      sum_q        <= sum_d;
      snap_q       <= snap_d;
      thr_q        <= thr_d;
      stage_q      <= stage_d;
      ci_q         <= ci_d;
      done_q       <= done_d;
      last_q       <= last_d;
      prog_q       <= prog_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      mean_valid_q <= mean_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.ci_o            = ci_q;
  assign bus.done_o          = done_q;
  assign bus.progress_done_o = prog_q;
  assign bus.mean_o          = thr_q;
  assign bus.mean_valid_o    = mean_valid_q;
  assign bus.overrun_o       = overrun_q;
endmodule

// File: tb/tb_mrelbp_ci_multi_r.sv
// Scoreboard bench for mrelbp_ci_multi_r: frame-level reference model feeds expectation queues,
// a negedge monitor pops and compares whenever the DUT presents results.
module tb_mrelbp_ci_multi_r;
  localparam int DW      = 8;
  localparam int ROWS    = 30;
  localparam int COLS    = 30;
  localparam int NR      = 4;
  localparam int RS      = 2;
  localparam int SUMW    = DW + $clog2(ROWS * COLS);
  localparam int DIV_LAT = NR * (SUMW + 1) + 1;

  localparam int MODE_CONST = 0;
  localparam int MODE_RAMP  = 1;
  localparam int MODE_RAND  = 2;

  logic clk;
  logic rst;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mrelbp_ci_multi_r_if #(.DATA_W(DW), .NUM_R(NR)) bus ();

  mrelbp_ci_multi_r #(
    .DATA_W(DW), .ROWS(ROWS), .COLS(COLS), .NUM_R(NR), .R_STEP(RS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            cyc;
    logic [NR-1:0] dn;
    logic [NR-1:0] ci;
    logic [NR-1:0] last;
  } exp_t;

  typedef struct {
    int               cyc;
    logic [NR*DW-1:0] m;
  } mexp_t;

  exp_t  eq[$];
  mexp_t mq[$];

  int checks = 0;
  int errors = 0;

  int            mrow, mcol, busy_until, pend_cyc;
  int            msum     [NR];
  logic [DW-1:0] mthr     [NR];
  logic [DW-1:0] pend_thr [NR];
  bit            pend_v, movr;
  bit            ext_sel;
  logic [DW-1:0] ext_thr;
  logic [NR-1:0] prog_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NR*DW-1:0] pack_thr();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = mthr[k];
    return v;
  endfunction

  task automatic model_reset();
    mrow = 0;
    mcol = 0;
    for (int k = 0; k < NR; k++) begin
      msum[k] = 0;
      mthr[k] = DW'(1 << (DW - 1));
    end
    pend_v     = 1'b0;
    pend_cyc   = 0;
    busy_until = -1;
    movr       = 1'b0;
    prog_exp   = '0;
    eq.delete();
    mq.delete();
  endtask

  // Pixel sampled on posedge e: CI vs the frame mean in force, means due DIV_LAT after frame end.
  task automatic model_pixel(input logic [DW-1:0] pix, input int e);
    exp_t          x;
    mexp_t         mx;
    int            r;
    logic [DW-1:0] t;
    if (pend_v && e >= pend_cyc) begin
      for (int k = 0; k < NR; k++) mthr[k] = pend_thr[k];
      pend_v = 1'b0;
    end
    x.cyc  = e;
    x.dn   = '0;
    x.ci   = '0;
    x.last = '0;
    for (int k = 0; k < NR; k++) begin
      r = RS * (k + 1);
      if (mrow >= r && mrow <= ROWS - 1 - r && mcol >= r && mcol <= COLS - 1 - r) begin
        t         = ext_sel ? ext_thr : mthr[k];
        x.dn[k]   = 1'b1;
        x.ci[k]   = (pix >= t);
        x.last[k] = (mrow == ROWS - 1 - r) && (mcol == COLS - 1 - r);
        msum[k]  += int'(pix);
      end
    end
    if (x.dn != '0) eq.push_back(x);
    if (mrow == ROWS - 1 && mcol == COLS - 1) begin
      if (e <= busy_until) begin
        movr = 1'b1;
      end else begin
        mx.cyc = e + DIV_LAT;
        mx.m   = '0;
        for (int k = 0; k < NR; k++) begin
          r           = RS * (k + 1);
          pend_thr[k] = DW'(msum[k] / ((ROWS - 2 * r) * (COLS - 2 * r)));
          mx.m[k*DW +: DW] = pend_thr[k];
        end
        pend_v     = 1'b1;
        pend_cyc   = e + DIV_LAT + 1;
        busy_until = e + DIV_LAT;
        mq.push_back(mx);
      end
      for (int k = 0; k < NR; k++) msum[k] = 0;
    end
    if (mcol == COLS - 1) begin
      mcol = 0;
      mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t          x;
    mexp_t         mx;
    logic [NR-1:0] nxt_prog;
    if (!rst) begin
      nxt_prog = '0;
      if (eq.size() > 0 && eq[0].cyc == cyc) begin
        x = eq.pop_front();
        chk("done_o", 64'(bus.done_o), 64'(x.dn));
        chk("ci_o", 64'(bus.ci_o & x.dn), 64'(x.ci & x.dn));
        nxt_prog = x.last;
      end else if (bus.done_o != '0) begin
        chk("done_o_idle", 64'(bus.done_o), 64'd0);
      end
      if (prog_exp != '0 || bus.progress_done_o != '0)
        chk("progress_done_o", 64'(bus.progress_done_o), 64'(prog_exp));
      prog_exp = nxt_prog;
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        mx = mq.pop_front();
        chk("mean_valid_o", 64'(bus.mean_valid_o), 64'd1);
        chk("mean_o", 64'(bus.mean_o), 64'(mx.m));
      end else if (bus.mean_valid_o) begin
        chk("mean_valid_o_idle", 64'(bus.mean_valid_o), 64'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.done_i  = 1'b0;
      bus.pixel_i = DW'($urandom);
    end
  endtask

  task automatic send(input logic [DW-1:0] pix, input bit gappy);
    if (gappy) begin
      while ($urandom_range(1, 0) == 0) idle(1);
    end
    @(negedge clk);
    bus.done_i  = 1'b1;
    bus.pixel_i = pix;
    model_pixel(pix, cyc + 1);
  endtask

  task automatic frame(input int mode, input logic [DW-1:0] val, input bit gappy);
    logic [DW-1:0] p;
    for (int i = 0; i < ROWS * COLS; i++) begin
      case (mode)
        MODE_CONST: p = val;
        MODE_RAMP:  p = DW'(8 * (i % COLS));
        default:    p = DW'($urandom);
      endcase
      send(p, gappy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [NR*DW-1:0] thr_rst;
    thr_rst = '0;
    for (int k = 0; k < NR; k++) thr_rst[k*DW +: DW] = DW'(1 << (DW - 1));
    chk({tag, "_done_o"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_ci_o"}, 64'(bus.ci_o), 64'd0);
    chk({tag, "_progress_done_o"}, 64'(bus.progress_done_o), 64'd0);
    chk({tag, "_mean_valid_o"}, 64'(bus.mean_valid_o), 64'd0);
    chk({tag, "_overrun_o"}, 64'(bus.overrun_o), 64'd0);
    chk({tag, "_mean_o"}, 64'(bus.mean_o), 64'(thr_rst));
  endtask

  initial begin
    rst         = 1'b1;
    bus.done_i  = 1'b0;
    bus.pixel_i = '0;
    ext_sel     = 1'b0;
    ext_thr     = '0;
`ifdef MRELBP_CI_EXT_THR_EN
    bus.thr_sel_i = 1'b0;
    bus.thr_i     = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    frame(MODE_CONST, DW'(100), 1'b0);
    idle(100);
    frame(MODE_CONST, DW'(100), 1'b0);
    idle(100);
    // Back-to-back ramps: early centres of the second frame still see the older mean.
    frame(MODE_RAMP, '0, 1'b0);
    frame(MODE_RAMP, '0, 1'b0);
    idle(100);
    frame(MODE_RAMP, '0, 1'b1);
    frame(MODE_RAMP, '0, 1'b1);
    idle(100);
    frame(MODE_RAND, '0, 1'b0);
    idle(100);

    for (int i = 0; i < 100; i++) send(DW'($urandom), 1'b1);
    idle(3);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    bus.done_i = 1'b0;
    check_reset_state("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    frame(MODE_CONST, DW'(100), 1'b0);
    idle(100);

`ifdef MRELBP_CI_EXT_THR_EN
    ext_sel       = 1'b1;
    ext_thr       = DW'(50);
    bus.thr_sel_i = 1'b1;
    bus.thr_i     = DW'(50);
    frame(MODE_CONST, DW'(60), 1'b0);
    idle(100);
    ext_sel       = 1'b0;
    bus.thr_sel_i = 1'b0;
    frame(MODE_CONST, DW'(60), 1'b1);
    idle(100);
`endif

    if (pend_v && cyc + 1 >= pend_cyc) begin
      for (int k = 0; k < NR; k++) mthr[k] = pend_thr[k];
      pend_v = 1'b0;
    end
    chk("final_mean_o", 64'(bus.mean_o), 64'(pack_thr()));
    chk("final_overrun_o", 64'(bus.overrun_o), 64'(movr));
    chk("pending_ci_results", 64'(eq.size()), 64'd0);
    chk("pending_mean_results", 64'(mq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
